// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: fractional tick generator, 3-sample majority bit
// decisions and a one-entry ready/valid holding register for received bytes.
module uart_rx_os #(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned OVERSAMPLING = 8,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned AW   = $clog2(CLK_FREQ / BAUD) + 8;
    localparam int unsigned ACCW = AW + 1;
    localparam int unsigned OSW  = $clog2(OVERSAMPLING);
    localparam int unsigned BCW  = $clog2(DATA_BITS);
    localparam int unsigned MID  = OVERSAMPLING / 2;

    localparam logic [63:0] INC64 =
        ((64'(BAUD) * 64'(OVERSAMPLING) << AW) + 64'(CLK_FREQ) / 64'd2) / 64'(CLK_FREQ);
    localparam logic [AW:0] INC = ACCW'(INC64);

    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLING - 1);
    localparam logic [OSW-1:0] OS_DEC   = OSW'(MID + 1);
    localparam logic [OSW-1:0] OS_ONE   = OSW'(1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    localparam logic [2:0] ST_ARM   = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [AW:0]          acc_q, acc_d;
    logic [1:0]           samp_q, samp_d;
    logic [2:0]           state_q, state_d;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;

    logic rxs;
    logic tick;
    logic maj;
    logic dec;
    logic wrap;
    logic deliver;

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = busy_q;

    // Next-state logic: synchronizer, tick generator, frame FSM, holding register
    always_comb begin
        sync1_d    = rxd;
        sync2_d    = sync1_q;
        acc_d      = {1'b0, acc_q[AW-1:0]} + INC;
        samp_d     = samp_q;
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        deliver    = 1'b0;

        rxs  = sync2_q;
        tick = acc_q[AW];
        // Window = samples from the two previous ticks plus the current one
        maj  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
        dec  = (os_cnt_q == OS_DEC);
        wrap = (os_cnt_q == OS_LAST);

        if (tick) begin
            samp_d   = {samp_q[0], rxs};
            os_cnt_d = wrap ? '0 : os_cnt_q + OSW'(1);
            case (state_q)
                ST_ARM: begin
                    if (rxs) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    // The detecting tick is sample 0 of the start bit
                    if (!rxs) begin
                        state_d  = ST_START;
                        os_cnt_d = OS_ONE;
                    end
                end
                ST_START: begin
                    if (dec && maj) begin
                        state_d = ST_IDLE;
                    end else if (wrap) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
                        else                       bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                ST_STOP: begin
                    if (dec) begin
                        if (maj) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_ARM;
                        end
                    end
                end
                default: state_d = ST_ARM;
            endcase
        end

        // A same-cycle drain frees the slot for the new byte
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_ARM) && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            acc_q      <= '0;
            samp_q     <= '1;
            state_q    <= ST_ARM;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            acc_q      <= acc_d;
            samp_q     <= samp_d;
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 1 MHz / 62500 baud / 8x oversampling (16 clk per bit).
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    int   cyc      = 0;
    int   n_ferr   = 0;
    int   n_ovr    = 0;
    int   rise_cyc = -1;
    logic prev_v   = 1'b0;

    uart_rx_os #(
        .CLK_FREQ    (1000000),
        .BAUD        (62500),
        .OVERSAMPLING(8),
        .DATA_BITS   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and rx_valid rise timestamp
    always @(negedge clk) begin
        if (rx_frame_err) n_ferr++;
        if (rx_overrun)   n_ovr++;
        if (rx_valid && !prev_v) rise_cyc = cyc;
        prev_v = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive the first nbits of {stop, byte, start}; per100 is the bit period in 1/100 clk
    task automatic send_frame(input logic [7:0] b, input int per100, input logic stop_v, input int nbits);
        logic [9:0] fr;
        int t;
        fr = {stop_v, b, 1'b0};
        t  = 0;
        for (int i = 0; i < nbits; i++) begin
            rxd = fr[i];
            while (t < ((i + 1) * per100 + 50) / 100) begin
                step();
                t++;
            end
        end
    endtask

    task automatic wait_valid(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (rx_valid) ok = 1'b1;
    endtask

    task automatic consume(input string tag, input logic [7:0] exp);
        logic ok;
        wait_valid(40, ok);
        chk({tag, "_valid"}, 32'(ok), 32'd1);
        chk({tag, "_data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        chk({tag, "_drained"}, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        int   f0;
        int   o0;
        int   s1;
        int   s2;
        int   lat;
        logic ok;

        rst      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        steps(4);
        chk("rst_data",  32'(rx_data),      32'd0);
        chk("rst_valid", 32'(rx_valid),     32'd0);
        chk("rst_ferr",  32'(rx_frame_err), 32'd0);
        chk("rst_ovr",   32'(rx_overrun),   32'd0);
        chk("rst_busy",  32'(rx_busy),      32'd0);
        rst = 1'b0;
        steps(20);

        // 1: 0xA5 held until drained
        f0 = n_ferr;
        o0 = n_ovr;
        send_frame(8'hA5, 1600, 1'b1, 10);
        wait_valid(40, ok);
        chk("a5_valid", 32'(ok), 32'd1);
        steps(10);
        chk("a5_hold_valid", 32'(rx_valid), 32'd1);
        chk("a5_hold_data",  32'(rx_data),  32'hA5);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        chk("a5_drained", 32'(rx_valid), 32'd0);
        steps(3);
        chk("a5_stay_low", 32'(rx_valid), 32'd0);
        chk("a5_ferr", 32'(n_ferr - f0), 32'd0);
        chk("a5_ovr",  32'(n_ovr - o0),  32'd0);

        // 2: short glitch rejected, then 0x3C
        steps(8);
        rxd = 1'b0;
        steps(3);
        rxd = 1'b1;
        steps(16);
        chk("glitch_busy",  32'(rx_busy),  32'd0);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h3C, 1600, 1'b1, 10);
        consume("glitch_3c", 8'h3C);

        // 3: bad stop bit, line held low, then recovery
        steps(8);
        f0 = n_ferr;
        send_frame(8'h00, 1600, 1'b0, 10);
        steps(40);
        chk("brk_ferr",  32'(n_ferr - f0), 32'd1);
        chk("brk_valid", 32'(rx_valid),    32'd0);
        chk("brk_busy",  32'(rx_busy),     32'd0);
        rxd = 1'b1;
        steps(20);
        send_frame(8'h3C, 1600, 1'b1, 10);
        consume("brk_3c", 8'h3C);
        chk("brk_ferr_after", 32'(n_ferr - f0), 32'd1);

        // 4a: back-to-back with no drain -> overrun, first byte kept
        steps(8);
        o0 = n_ovr;
        send_frame(8'h11, 1600, 1'b1, 10);
        send_frame(8'h22, 1600, 1'b1, 10);
        steps(10);
        chk("ovr_valid", 32'(rx_valid),   32'd1);
        chk("ovr_data",  32'(rx_data),    32'h11);
        chk("ovr_pulse", 32'(n_ovr - o0), 32'd1);
        consume("ovr_11", 8'h11);

        // 4b: drain in the delivery cycle of the second byte -> no overrun
        steps(8);
        o0 = n_ovr;
        s1 = cyc;
        send_frame(8'h11, 1600, 1'b1, 10);
        lat = rise_cyc - s1;
        chk("lat_range", 32'((lat > 140) && (lat <= 170)), 32'd1);
        s2 = cyc;
        fork
            send_frame(8'h22, 1600, 1'b1, 10);
            begin
                while (cyc < s2 + lat - 1) step();
                rx_ready = 1'b1;
                step();
                rx_ready = 1'b0;
            end
        join
        steps(4);
        chk("same_valid", 32'(rx_valid),   32'd1);
        chk("same_data",  32'(rx_data),    32'h22);
        chk("same_ovr",   32'(n_ovr - o0), 32'd0);
        consume("same_22", 8'h22);

        // 5: +/-2% baud mismatch
        f0 = n_ferr;
        steps(8);
        send_frame(8'h55, 1568, 1'b1, 10);
        consume("fast_55", 8'h55);
        steps(8);
        send_frame(8'hFF, 1568, 1'b1, 10);
        consume("fast_ff", 8'hFF);
        steps(8);
        send_frame(8'h55, 1632, 1'b1, 10);
        consume("slow_55", 8'h55);
        steps(8);
        send_frame(8'hFF, 1632, 1'b1, 10);
        consume("slow_ff", 8'hFF);
        chk("drift_ferr", 32'(n_ferr - f0), 32'd0);

        // 6: reset during data bit 3 of 0x81
        steps(8);
        f0 = n_ferr;
        o0 = n_ovr;
        send_frame(8'h81, 1600, 1'b1, 4);
        rxd = 1'b0;
        steps(8);
        chk("mid_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        rxd = 1'b1;
        steps(32);
        chk("mrst_data",  32'(rx_data),      32'd0);
        chk("mrst_valid", 32'(rx_valid),     32'd0);
        chk("mrst_ferr",  32'(rx_frame_err), 32'd0);
        chk("mrst_ovr",   32'(rx_overrun),   32'd0);
        chk("mrst_busy",  32'(rx_busy),      32'd0);
        rst = 1'b0;
        steps(40);
        chk("post_valid", 32'(rx_valid),    32'd0);
        chk("post_busy",  32'(rx_busy),     32'd0);
        chk("post_ferr",  32'(n_ferr - f0), 32'd0);
        chk("post_ovr",   32'(n_ovr - o0),  32'd0);
        send_frame(8'h7E, 1600, 1'b1, 10);
        consume("post_7e", 8'h7E);

        steps(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
